// File: rtl/encoder_8b10b_pkg.sv
// Shared types and control-symbol codes for the 8b10b transmit path.
package encoder_8b10b_pkg;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    SOF,
    PAYLOAD,
    EOF
  } state_t;

  localparam logic [7:0] K28_5 = 8'hBC;  // comma / idle fill
  localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
  localparam logic [7:0] K29_7 = 8'hFD;  // end of frame

endpackage

// File: rtl/encoder_8b10b_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               vld
);

  logic [PTR_W:0] w_cand;

  always_comb begin
    gnt    = '0;
    idx    = '0;
    vld    = 1'b0;
    w_cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (w_cand >= (PTR_W+1)'(NUM_REQ)) w_cand = w_cand - (PTR_W+1)'(NUM_REQ);
      if (en && !vld && req[w_cand[PTR_W-1:0]]) begin
        vld                     = 1'b1;
        gnt[w_cand[PTR_W-1:0]]  = 1'b1;
        idx                     = w_cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/encoder_8b10b_tx_scheduler.sv
// Symbol sequencer ahead of the 8b10b encoder: sync burst, comma fill, and
// round-robin framed transfers (SOF / payload / EOF) from NUM_REQ requesters.
module encoder_8b10b_tx_scheduler
  import encoder_8b10b_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MAX_LEN     = 16,
  parameter int LEN_W       = 4,
  parameter int SYNC_COMMAS = 16,
  parameter int IFG_MIN     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sym_en,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*8-1:0]     data_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       data_pop,
  output logic [7:0]               enc_data,
  output logic                     enc_k,
  output logic                     link_up,
  output logic                     frame_done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SC_W  = (SYNC_COMMAS > 1) ? $clog2(SYNC_COMMAS) : 1;
  localparam int GAP_W = $clog2(IFG_MIN + 1);

  state_t             r_state, w_state_nxt;
  logic [SC_W-1:0]    r_sync_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [PTR_W-1:0]   r_rr_ptr, r_winner, w_win_idx;
  logic [NUM_REQ-1:0] r_grant, w_arb_gnt;
  logic [LEN_W-1:0]   r_len, r_byte_cnt, w_win_len;
  logic               r_link_up, r_frame_done;
  logic               w_gap_ok, w_arb_vld, w_start;
  logic [7:0]         w_pay_byte;

  // Counting the current IDLE symbol toward the gap guarantees IFG_MIN commas before SOF.
  assign w_gap_ok = ({1'b0, r_gap_cnt} + 1'b1) >= (GAP_W+1)'(IFG_MIN);
  assign w_start  = sym_en && w_arb_vld;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req (req),
    .ptr (r_rr_ptr),
    .en  ((r_state == IDLE) && w_gap_ok),
    .gnt (w_arb_gnt),
    .idx (w_win_idx),
    .vld (w_arb_vld)
  );

  always_comb begin
    w_win_len  = '0;
    w_pay_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_idx == PTR_W'(i)) w_win_len  = req_len[i*LEN_W +: LEN_W];
      if (r_winner  == PTR_W'(i)) w_pay_byte = data_in[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= SYNC;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (sym_en) begin
      case (r_state)
        SYNC:    if (r_sync_cnt == SC_W'(SYNC_COMMAS - 1)) w_state_nxt = IDLE;
        IDLE:    if (w_start) w_state_nxt = SOF;
        SOF:     w_state_nxt = PAYLOAD;
        PAYLOAD: if (r_byte_cnt == r_len) w_state_nxt = EOF;
        EOF:     w_state_nxt = IDLE;
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_rr_ptr     <= '0;
      r_winner     <= '0;
      r_grant      <= '0;
      r_len        <= '0;
      r_byte_cnt   <= '0;
      r_link_up    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (sym_en) begin
        case (r_state)
          SYNC: begin
            if (r_sync_cnt == SC_W'(SYNC_COMMAS - 1)) begin
              r_link_up <= 1'b1;
              r_gap_cnt <= GAP_W'(IFG_MIN);
            end else begin
              r_sync_cnt <= r_sync_cnt + 1'b1;
            end
          end
          IDLE: begin
            if (r_gap_cnt != GAP_W'(IFG_MIN)) r_gap_cnt <= r_gap_cnt + 1'b1;
            if (w_start) begin
              r_grant  <= w_arb_gnt;
              r_winner <= w_win_idx;
              r_len    <= w_win_len;
            end
          end
          SOF:     r_byte_cnt <= '0;
          PAYLOAD: r_byte_cnt <= r_byte_cnt + 1'b1;
          EOF: begin
            r_grant      <= '0;
            r_gap_cnt    <= '0;
            r_frame_done <= 1'b1;
            r_rr_ptr     <= (r_winner == PTR_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    enc_data = K28_5;
    enc_k    = 1'b1;
    case (r_state)
      SOF:     enc_data = K27_7;
      PAYLOAD: begin
        enc_data = w_pay_byte;
        enc_k    = 1'b0;
      end
      EOF:     enc_data = K29_7;
      default: ;
    endcase
  end

  assign data_pop   = r_grant & {NUM_REQ{sym_en && (r_state == PAYLOAD)}};
  assign grant      = r_grant;
  assign link_up    = r_link_up;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_encoder_8b10b_tx_scheduler.sv
// Scoreboard bench for encoder_8b10b_tx_scheduler: expected frames are queued
// as requests are raised and compared symbol by symbol as the encoder consumes them.
module tb_encoder_8b10b_tx_scheduler;
  import encoder_8b10b_pkg::*;

  localparam int NR  = 2;
  localparam int LW  = 4;
  localparam int ML  = 16;
  localparam int SC  = 16;
  localparam int IFG = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             sym_en;
  logic [NR-1:0]    req;
  logic [NR*LW-1:0] req_len;
  logic [NR*8-1:0]  data_in;
  logic [NR-1:0]    grant, data_pop;
  logic [7:0]       enc_data;
  logic             enc_k, link_up, frame_done;

  encoder_8b10b_tx_scheduler #(
    .NUM_REQ(NR), .MAX_LEN(ML), .LEN_W(LW), .SYNC_COMMAS(SC), .IFG_MIN(IFG)
  ) dut (
    .clk(clk), .reset(reset), .sym_en(sym_en), .req(req), .req_len(req_len),
    .data_in(data_in), .grant(grant), .data_pop(data_pop), .enc_data(enc_data),
    .enc_k(enc_k), .link_up(link_up), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int          n_chk, n_pass;
  logic [7:0]  payload [NR][ML+1];
  int          ptr [NR];
  int          rem [NR];
  logic [LW-1:0] len_cfg [NR];
  logic [8:0]  exp_q [$];
  int          own_q [$];
  int          gap_run, sync_run, fd_cnt;
  int          pop_cnt [NR];
  bit          seen_eof, exact_gap, sb_en;
  logic [NR-1:0] prev_grant;

  task automatic drive_model();
    for (int r = 0; r < NR; r++) begin
      req[r]               = (rem[r] > 0);
      req_len[r*LW +: LW]  = len_cfg[r];
      data_in[r*8 +: 8]    = payload[r][ptr[r]];
    end
  endtask

  task automatic push_frame(input int r);
    exp_q.push_back({1'b1, K27_7});
    for (int i = 0; i <= int'(len_cfg[r]); i++) exp_q.push_back({1'b0, payload[r][i]});
    exp_q.push_back({1'b1, K29_7});
    own_q.push_back(r);
  endtask

  // One clock: inputs set after the edge, outputs sampled at negedge, requester model updated after the edge.
  task automatic step(input bit en);
    logic [8:0]    sym, e;
    logic [NR-1:0] pops;
    int            o;
    sym_en = en;
    drive_model();
    @(negedge clk);
    pops = data_pop;
    if (!en) begin
      n_chk++;
      if (data_pop !== '0) $display("FAIL pop_without_sym_en: data_pop=%b required 0", data_pop);
      else n_pass++;
    end
    if (en && !reset) begin
      sym = {enc_k, enc_data};
      for (int r = 0; r < NR; r++) pop_cnt[r] += int'(pops[r]);
      if (!link_up) begin
        n_chk++;
        if (sym !== {1'b1, K28_5}) $display("FAIL sync_sym: got %h required 1bc", sym);
        else n_pass++;
        sync_run++;
      end else if (sym === {1'b1, K28_5}) begin
        gap_run++;
      end else if (sb_en) begin
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL unexpected_sym: got %h with empty scoreboard", sym);
        else begin
          e = exp_q.pop_front();
          if (sym !== e) $display("FAIL frame_sym: got %h required %h", sym, e);
          else n_pass++;
        end
        if (sym === {1'b1, K27_7}) begin
          if (seen_eof) begin
            n_chk++;
            if (gap_run < IFG || (exact_gap && gap_run != IFG))
              $display("FAIL ifg: got %0d commas required %s%0d", gap_run, exact_gap ? "" : ">=", IFG);
            else n_pass++;
          end
          if (own_q.size() > 0) begin
            o = own_q.pop_front();
            n_chk++;
            if (grant !== NR'(1 << o)) $display("FAIL owner: grant=%b required %b", grant, NR'(1 << o));
            else n_pass++;
          end
          gap_run = 0;
        end
        if (sym === {1'b1, K29_7}) seen_eof = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++) begin
      if (pops[r] && ptr[r] < ML) ptr[r]++;
      if (!grant[r]) ptr[r] = 0;
      if (grant[r] && !prev_grant[r] && rem[r] > 0) rem[r]--;
    end
    prev_grant = grant;
    if (frame_done) fd_cnt++;
    drive_model();
  endtask

  task automatic run_frames(input int max_steps, input bit toggle);
    int n = 0;
    while (exp_q.size() > 0 && n < max_steps) begin
      step(toggle ? (n % 2 == 0) : 1'b1);
      n++;
    end
    for (int i = 0; i < 3; i++) step(1'b1);
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL frame_timeout: %0d symbols still expected, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic clear_model();
    exp_q.delete();
    own_q.delete();
    for (int r = 0; r < NR; r++) begin
      rem[r] = 0; ptr[r] = 0; pop_cnt[r] = 0;
    end
    gap_run = 0; sync_run = 0; fd_cnt = 0;
    seen_eof = 1'b0; exact_gap = 1'b0; sb_en = 1'b1;
    prev_grant = '0;
  endtask

  task automatic resync();
    clear_model();
    reset  = 1'b1;
    sym_en = 1'b0;
    drive_model();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < SC; i++) step(1'b1);
  endtask

  task automatic test_reset();
    clear_model();
    reset  = 1'b1;
    sym_en = 1'b1;
    drive_model();
    #2;
    n_chk++; if (grant !== '0) $display("FAIL rst_grant: got %b required 0", grant); else n_pass++;
    n_chk++; if (data_pop !== '0) $display("FAIL rst_pop: got %b required 0", data_pop); else n_pass++;
    n_chk++; if ({enc_k, enc_data} !== {1'b1, K28_5}) $display("FAIL rst_sym: got %b/%h required 1/bc", enc_k, enc_data); else n_pass++;
    n_chk++; if (link_up !== 1'b0) $display("FAIL rst_link_up: got %b required 0", link_up); else n_pass++;
    n_chk++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b required 0", frame_done); else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_sync();
    for (int i = 0; i < SC; i++) step(1'b1);
    n_chk++; if (sync_run != SC) $display("FAIL sync_len: got %0d required %0d", sync_run, SC); else n_pass++;
    n_chk++; if (link_up !== 1'b1) $display("FAIL link_up: got %b required 1", link_up); else n_pass++;
    for (int i = 0; i < 4; i++) step(1'b1);
    n_chk++; if (gap_run != 4) $display("FAIL idle_commas: got %0d required 4", gap_run); else n_pass++;
  endtask

  task automatic test_single_frame();
    len_cfg[0] = 4'd3; pop_cnt[0] = 0; fd_cnt = 0;
    push_frame(0);
    rem[0] = 1;
    run_frames(40, 1'b0);
    n_chk++; if (pop_cnt[0] != 4) $display("FAIL single_pops: got %0d required 4", pop_cnt[0]); else n_pass++;
    n_chk++; if (fd_cnt != 1) $display("FAIL single_frame_done: got %0d required 1", fd_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    resync();
    len_cfg[0] = 4'd0; len_cfg[1] = 4'd0;
    exact_gap = 1'b1;
    for (int f = 0; f < 6; f++) push_frame(f % 2);
    rem[0] = 3; rem[1] = 3;
    run_frames(120, 1'b0);
    exact_gap = 1'b0;
    n_chk++; if (fd_cnt != 6) $display("FAIL b2b_frame_done: got %0d required 6", fd_cnt); else n_pass++;
  endtask

  task automatic test_sym_en_toggle();
    len_cfg[0] = 4'd3; pop_cnt[0] = 0; fd_cnt = 0;
    push_frame(0);
    rem[0] = 1;
    run_frames(80, 1'b1);
    n_chk++; if (pop_cnt[0] != 4) $display("FAIL toggle_pops: got %0d required 4", pop_cnt[0]); else n_pass++;
    n_chk++; if (fd_cnt != 1) $display("FAIL toggle_frame_done: got %0d required 1", fd_cnt); else n_pass++;
  endtask

  task automatic test_len_max();
    len_cfg[1] = 4'hF; pop_cnt[1] = 0;
    push_frame(1);
    rem[1] = 1;
    run_frames(100, 1'b0);
    n_chk++; if (pop_cnt[1] != ML) $display("FAIL max_pops: got %0d required %0d", pop_cnt[1], ML); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    len_cfg[0] = 4'd3; pop_cnt[0] = 0; sb_en = 1'b0;
    rem[0] = 1;
    while (pop_cnt[0] < 2 && n < 40) begin
      step(1'b1);
      n++;
    end
    n_chk++; if (pop_cnt[0] != 2) $display("FAIL mid_reach: got %0d pops required 2", pop_cnt[0]); else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++; if (grant !== '0) $display("FAIL mid_grant: got %b required 0", grant); else n_pass++;
    n_chk++; if ({enc_k, enc_data} !== {1'b1, K28_5}) $display("FAIL mid_sym: got %b/%h required 1/bc", enc_k, enc_data); else n_pass++;
    n_chk++; if (link_up !== 1'b0) $display("FAIL mid_link_up: got %b required 0", link_up); else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    clear_model();
    push_frame(0);
    rem[0] = 1;
    run_frames(60, 1'b0);
    n_chk++; if (sync_run != SC) $display("FAIL mid_resync: got %0d commas required %0d", sync_run, SC); else n_pass++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    for (int i = 0; i <= ML; i++) begin
      payload[0][i] = 8'((i + 1) * 17);
      payload[1][i] = 8'(8'hA0 + i);
    end
    len_cfg[0] = '0; len_cfg[1] = '0;
    test_reset();
    test_sync();
    test_single_frame();
    test_back_to_back();
    test_sym_en_toggle();
    test_len_max();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
